// File: rtl/mc_controller_if.sv
// ---------------------------------------------------------------------------
// mc_controller_if
//   Bundle between the multi-cycle MIPS control unit and its datapath.
//   master : control unit side (takes instruction fields/status, drives
//            datapath controls, debug state and error flags)
//   slave  : datapath side (the mirror image)
//   Signals:
//     op, funct        instr[31:26], instr[5:0]
//     zero, lt         ALU zero flag and sign of a-b
//     memready         memory completes the current access this cycle
//     pcen .. extop    single-bit datapath enables / selects
//     memtoreg, regdst, alusrcb, pcsrc   2-bit mux selects
//     alucontrol       4-bit ALU operation
//     state            current FSM state (debug)
//     buserr, illegal  sticky error flags
// ---------------------------------------------------------------------------
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       lt;
  logic       memready;

  logic       pcen;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       extop;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic [4:0] state;
  logic       buserr;
  logic       illegal;

  modport master (
    input  op, funct, zero, lt, memready,
    output pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, extop,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, state, buserr, illegal
  );

  modport slave (
    output op, funct, zero, lt, memready,
    input  pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, extop,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, state, buserr, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Multi-cycle MIPS control unit: main FSM plus ALU decode.
//   Memory states (FETCH, MEMRD, MEMWR) hold their request until memready,
//   with an optional wait-cycle timeout that latches a sticky bus error and
//   parks the FSM in HALT. Unknown instructions latch a sticky illegal flag
//   and either halt or are dropped as a NOP.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    mc_controller_if.master (instruction fields, status, controls)
//   Parameters:
//     TIMEOUT          wait cycles tolerated on one access (0 = never time out)
//     WAIT_W           wait counter width, TIMEOUT < 2**WAIT_W
//     HALT_ON_ILLEGAL  1 = illegal instruction halts, 0 = treated as NOP
// ---------------------------------------------------------------------------
module mc_controller #(
  parameter int TIMEOUT         = 15,
  parameter int WAIT_W          = 4,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_RTYPEEX = 5'd6,
    S_RTYPEWB = 5'd7,
    S_BEQEX   = 5'd8,
    S_IMMEX   = 5'd9,
    S_IMMWB   = 5'd10,
    S_JEX     = 5'd11,
    S_BLEEX   = 5'd12,
    S_BNEEX   = 5'd13,
    S_JALEX   = 5'd14,
    S_JREX    = 5'd15,
    S_HALT    = 5'd31
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLE  = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [WAIT_W-1:0] TO_CNT   = WAIT_W'(TIMEOUT);
  localparam bit                TO_EN    = (TIMEOUT != 0);
  localparam bit                HALT_ILL = (HALT_ON_ILLEGAL != 0);

  // R-type ALU decode; jr is dispatched separately and never reaches RTYPEEX.
  function automatic logic [3:0] rtype_alu(input logic [5:0] f);
    logic [3:0] a;
    a = ALU_ADD;
    case (f)
      FN_ADD:  a = ALU_ADD;
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      FN_SLTU: a = ALU_SLTU;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic logic rfunct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT) || (f == FN_SLTU);
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] o);
    logic [3:0] a;
    a = ALU_ADD;
    case (o)
      OP_SLTI: a = ALU_SLT;
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              buserr_q, buserr_d;
  logic              illegal_q, illegal_d;
  logic              dec_bad;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      buserr_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      buserr_q  <= buserr_d;
      illegal_q <= illegal_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    buserr_d  = buserr_q;
    illegal_d = illegal_q;
    dec_bad   = 1'b0;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (bus.memready) begin
          wait_d = '0;
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (TO_EN && (wait_q == TO_CNT)) begin
          // Access never completed: give up and park until reset.
          wait_d   = '0;
          state_d  = S_HALT;
          buserr_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            if (bus.funct == FN_JR)       state_d = S_JREX;
            else if (rfunct_ok(bus.funct)) state_d = S_RTYPEEX;
            else                           dec_bad = 1'b1;
          end
          OP_BEQ:                          state_d = S_BEQEX;
          OP_BNE:                          state_d = S_BNEEX;
          OP_BLE:                          state_d = S_BLEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                            state_d = S_JEX;
          OP_JAL:                          state_d = S_JALEX;
          default:                         dec_bad = 1'b1;
        endcase
        if (dec_bad) begin
          illegal_d = 1'b1;
          state_d   = HALT_ILL ? S_HALT : S_FETCH;
        end
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_IMMEX:   state_d = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_IMMWB, S_BEQEX, S_BNEEX, S_BLEEX,
      S_JEX, S_JALEX, S_JREX: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  logic       pcen_c, memread_c, memwrite_c, irwrite_c, regwrite_c;
  logic       alusrca_c, iord_c, extop_c;
  logic [1:0] memtoreg_c, regdst_c, alusrcb_c, pcsrc_c;
  logic [3:0] alucontrol_c;

  always_comb begin
    pcen_c       = 1'b0;
    memread_c    = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    iord_c       = 1'b0;
    extop_c      = 1'b0;
    memtoreg_c   = 2'b00;
    regdst_c     = 2'b00;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    alucontrol_c = 4'b0000;
    case (state_q)
      S_FETCH: begin
        memread_c    = 1'b1;
        alusrcb_c    = 2'b01;
        alucontrol_c = ALU_ADD;
        // Only the completing cycle loads IR and advances PC, so PC moves once.
        irwrite_c    = bus.memready;
        pcen_c       = bus.memready;
      end
      S_DECODE: begin
        // Precompute branch target into aluout.
        alusrcb_c    = 2'b11;
        alucontrol_c = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_ADD;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 2'b01;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = rtype_alu(bus.funct);
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 2'b01;
      end
      S_BEQEX, S_BNEEX, S_BLEEX: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        case (state_q)
          S_BEQEX: pcen_c = bus.zero;
          S_BNEEX: pcen_c = ~bus.zero;
          default: pcen_c = bus.zero | bus.lt;   // a <= b
        endcase
      end
      S_IMMEX, S_IMMWB: begin
        // Extension and ALU op are held through writeback so aluout stays valid.
        alucontrol_c = imm_alu(bus.op);
        extop_c      = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
        if (state_q == S_IMMEX) begin
          alusrca_c = 1'b1;
          alusrcb_c = 2'b10;
        end else begin
          regwrite_c = 1'b1;
        end
      end
      S_JEX: begin
        pcen_c  = 1'b1;
        pcsrc_c = 2'b10;
      end
      S_JALEX: begin
        // PC still holds pc+4 at this edge, so r31 gets the return address
        // while PC loads the jump target.
        pcen_c     = 1'b1;
        pcsrc_c    = 2'b10;
        regwrite_c = 1'b1;
        regdst_c   = 2'b10;
        memtoreg_c = 2'b10;
      end
      S_JREX: begin
        pcen_c  = 1'b1;
        pcsrc_c = 2'b11;
      end
      default: ;
    endcase
  end

  // Side-effecting strobes are suppressed during reset so an abandoned access
  // cannot complete.
  assign bus.pcen       = pcen_c     & ~reset;
  assign bus.memread    = memread_c  & ~reset;
  assign bus.memwrite   = memwrite_c & ~reset;
  assign bus.irwrite    = irwrite_c  & ~reset;
  assign bus.regwrite   = regwrite_c & ~reset;
  assign bus.alusrca    = alusrca_c;
  assign bus.iord       = iord_c;
  assign bus.extop      = extop_c;
  assign bus.memtoreg   = memtoreg_c;
  assign bus.regdst     = regdst_c;
  assign bus.alusrcb    = alusrcb_c;
  assign bus.pcsrc      = pcsrc_c;
  assign bus.alucontrol = alucontrol_c;
  assign bus.state      = state_q;
  assign bus.buserr     = buserr_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] BLE  = 6'b000111;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] FJR  = 6'b001000;
  localparam int         TO   = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, lt, memready;
  int         tests = 0;
  int         fails = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  mc_controller_if ifh();
  mc_controller_if ifn();
  assign ifh.op = op;  assign ifh.funct = funct;  assign ifh.zero = zero;
  assign ifh.lt = lt;  assign ifh.memready = memready;
  assign ifn.op = op;  assign ifn.funct = funct;  assign ifn.zero = zero;
  assign ifn.lt = lt;  assign ifn.memready = memready;

  // dut_h halts on illegal instructions, dut_n drops them as NOPs.
  mc_controller #(.TIMEOUT(TO), .WAIT_W(4), .HALT_ON_ILLEGAL(1)) dut_h (
    .clk(clk), .reset(reset), .bus(ifh.master));
  mc_controller #(.TIMEOUT(TO), .WAIT_W(4), .HALT_ON_ILLEGAL(0)) dut_n (
    .clk(clk), .reset(reset), .bus(ifn.master));

  logic [26:0] obs_h, obs_n;
  assign obs_h = {ifh.pcen, ifh.memread, ifh.memwrite, ifh.irwrite, ifh.regwrite,
                  ifh.alusrca, ifh.iord, ifh.extop, ifh.memtoreg, ifh.regdst,
                  ifh.alusrcb, ifh.pcsrc, ifh.alucontrol, ifh.state, ifh.buserr, ifh.illegal};
  assign obs_n = {ifn.pcen, ifn.memread, ifn.memwrite, ifn.irwrite, ifn.regwrite,
                  ifn.alusrca, ifn.iord, ifn.extop, ifn.memtoreg, ifn.regdst,
                  ifn.alusrcb, ifn.pcsrc, ifn.alucontrol, ifn.state, ifn.buserr, ifn.illegal};

  // ------------------------------------------------------------------ model
  // An instruction is FETCH, DECODE, then a short list of execution steps;
  // pos indexes that list.
  typedef struct {
    int st;
    int pos;
    int wt;
    bit be;
    bit il;
  } mst_t;
  mst_t m [2];

  function automatic bit legal(logic [5:0] o, logic [5:0] f);
    bit ok;
    case (o)
      LW, SW, BEQ, BNE, BLE, ADDI, SLTI, ANDI, ORI, J, JAL: ok = 1'b1;
      R: ok = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
              (f == 6'b100101) || (f == 6'b101010) || (f == 6'b101011) || (f == FJR);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic int seq_at(logic [5:0] o, logic [5:0] f, int i);
    int s [3];
    int n;
    s = '{-1, -1, -1};
    n = 0;
    case (o)
      LW:  begin s = '{2, 3, 4};   n = 3; end
      SW:  begin s = '{2, 5, -1};  n = 2; end
      R:   if (f == FJR) begin s = '{15, -1, -1}; n = 1; end
           else          begin s = '{6, 7, -1};   n = 2; end
      BEQ: begin s = '{8, -1, -1};  n = 1; end
      BNE: begin s = '{13, -1, -1}; n = 1; end
      BLE: begin s = '{12, -1, -1}; n = 1; end
      ADDI, SLTI, ANDI, ORI: begin s = '{9, 10, -1}; n = 2; end
      J:   begin s = '{11, -1, -1}; n = 1; end
      JAL: begin s = '{14, -1, -1}; n = 1; end
      default: n = 0;
    endcase
    return (i >= 0 && i < n) ? s[i] : -1;
  endfunction

  function automatic mst_t mnext(mst_t s, bit hlt, logic rst, logic mr,
                                 logic [5:0] o, logic [5:0] f);
    mst_t n;
    n = s;
    if (rst) begin
      n.st = 0; n.pos = 0; n.wt = 0; n.be = 1'b0; n.il = 1'b0;
    end else if (s.st == 31) begin
      n = s;
    end else if ((s.st == 0 || s.st == 3 || s.st == 5) && !mr) begin
      if (s.wt == TO) begin n.st = 31; n.be = 1'b1; n.wt = 0; end
      else n.wt = s.wt + 1;
    end else begin
      n.wt = 0;
      if (s.st == 0) n.st = 1;
      else if (s.st == 1) begin
        if (!legal(o, f)) begin n.il = 1'b1; n.st = hlt ? 31 : 0; end
        else begin n.pos = 0; n.st = seq_at(o, f, 0); end
      end else begin
        n.pos = s.pos + 1;
        n.st  = seq_at(o, f, n.pos);
        if (n.st < 0) n.st = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] r_alu(logic [5:0] f);
    logic [3:0] a;
    case (f)
      6'b100010: a = 4'b0110;
      6'b100100: a = 4'b0000;
      6'b100101: a = 4'b0001;
      6'b101010: a = 4'b0111;
      6'b101011: a = 4'b1111;
      default:   a = 4'b0010;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] i_alu(logic [5:0] o);
    logic [3:0] a;
    case (o)
      SLTI:    a = 4'b0111;
      ANDI:    a = 4'b0000;
      ORI:     a = 4'b0001;
      default: a = 4'b0010;
    endcase
    return a;
  endfunction

  function automatic logic [26:0] expect_out(mst_t s, logic [5:0] o, logic [5:0] f,
                                             logic z, logic l, logic mr, logic rst);
    logic pcen, mrd, mwr, irw, rw, asa, iord, ext;
    logic [1:0] m2r, rdst, asb, psrc;
    logic [3:0] alu;
    {pcen, mrd, mwr, irw, rw, asa, iord, ext} = 8'h00;
    m2r = 2'b00; rdst = 2'b00; asb = 2'b00; psrc = 2'b00; alu = 4'b0000;
    case (s.st)
      0:  begin mrd = 1'b1; asb = 2'b01; alu = 4'b0010; irw = mr; pcen = mr; end
      1:  begin asb = 2'b11; alu = 4'b0010; end
      2:  begin asa = 1'b1; asb = 2'b10; alu = 4'b0010; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 2'b01; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin asa = 1'b1; alu = r_alu(f); end
      7:  begin rw = 1'b1; rdst = 2'b01; end
      8:  begin asa = 1'b1; alu = 4'b0110; psrc = 2'b01; pcen = z; end
      13: begin asa = 1'b1; alu = 4'b0110; psrc = 2'b01; pcen = !z; end
      12: begin asa = 1'b1; alu = 4'b0110; psrc = 2'b01; pcen = z | l; end
      9:  begin asa = 1'b1; asb = 2'b10; alu = i_alu(o); ext = (o == ANDI) || (o == ORI); end
      10: begin rw = 1'b1; alu = i_alu(o); ext = (o == ANDI) || (o == ORI); end
      11: begin pcen = 1'b1; psrc = 2'b10; end
      14: begin pcen = 1'b1; psrc = 2'b10; rw = 1'b1; rdst = 2'b10; m2r = 2'b10; end
      15: begin pcen = 1'b1; psrc = 2'b11; end
      default: ;
    endcase
    if (rst) {pcen, mrd, mwr, irw, rw} = 5'b00000;
    return {pcen, mrd, mwr, irw, rw, asa, iord, ext, m2r, rdst, asb, psrc, alu,
            5'(s.st), s.be, s.il};
  endfunction

  // Model advances on the same edge as the DUTs, from the inputs held over it.
  initial forever begin
    @(posedge clk);
    for (int h = 0; h < 2; h++)
      m[h] = mnext(m[h], (h == 0), reset, memready, op, funct);
  end

  // Cycle-by-cycle comparison of every output of both DUTs.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int h = 0; h < 2; h++) begin
        tests++;
        if (((h == 0) ? obs_h : obs_n) !== expect_out(m[h], op, funct, zero, lt, memready, reset)) begin
          fails++;
          $display("FAIL cycle_cmp dut%0d t=%0t act=%h exp=%h model_state=%0d", h, $time,
                   (h == 0) ? obs_h : obs_n,
                   expect_out(m[h], op, funct, zero, lt, memready, reset), m[h].st);
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; memready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int mrp,
                           output int cyc);
    int  c;
    bit  left;
    if (m[0].st == 31 || m[1].st != m[0].st) do_reset();
    op = o; funct = f; c = 0; left = 1'b0;
    while (c < 200) begin
      memready = ($urandom_range(99) < mrp);
      zero     = 1'($urandom_range(1));
      lt       = 1'($urandom_range(1));
      step();
      c++;
      if (m[0].st != 0) left = 1'b1;
      if (m[0].st == 31 || (left && m[0].st == 0)) break;
    end
    if (c >= 200) begin
      tests++; fails++;
      $display("FAIL run_instr_bound op=%b act=%0d cycles exp<200", o, c);
    end
    cyc = c;
  endtask

  task automatic imm_check(input logic [5:0] o, input logic e_ext, input logic [3:0] e_alu);
    op = o; funct = 6'b000000; memready = 1'b1;
    step(); step();
    chk("immex_state", 32'(ifh.state), 9);
    chk("immex_extop", 32'(ifh.extop), 32'(e_ext));
    chk("immex_alu", 32'(ifh.alucontrol), 32'(e_alu));
    step();
    chk("immwb_regwrite", 32'(ifh.regwrite), 1);
    chk("immwb_regdst", 32'(ifh.regdst), 0);
    step();
    chk("imm_back_fetch", 32'(ifh.state), 0);
  endtask

  task automatic br_check(input logic [5:0] o, input logic z, input logic l, input logic e_pcen);
    op = o; zero = z; lt = l; memready = 1'b1;
    step(); step();
    chk("br_pcen", 32'(ifh.pcen), 32'(e_pcen));
    chk("br_pcsrc", 32'(ifh.pcsrc), 1);
    step();
    chk("br_back_fetch", 32'(ifh.state), 0);
  endtask

  logic [5:0] ops [12];
  logic [5:0] fns [7];

  initial begin
    int c;
    logic [5:0] o, f;
    ops = '{LW, SW, R, BEQ, BNE, BLE, ADDI, SLTI, ANDI, ORI, J, JAL};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011, FJR};
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; lt = 1'b0; memready = 1'b0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_state", 32'(ifh.state), 0);
    chk("rst_buserr", 32'(ifh.buserr), 0);
    chk("rst_illegal", 32'(ifh.illegal), 0);
    chk("rst_memread_forced", 32'(ifh.memread), 0);
    reset = 1'b0; #1;
    chk("fetch_memread", 32'(ifh.memread), 1);

    // Fetch with three wait cycles.
    op = ADDI;
    for (int i = 0; i < 3; i++) begin
      memready = 1'b0; #1;
      chk("fetch_wait_irwrite", 32'(ifh.irwrite), 0);
      chk("fetch_wait_pcen", 32'(ifh.pcen), 0);
      step();
    end
    memready = 1'b1; #1;
    chk("fetch_done_irwrite", 32'(ifh.irwrite), 1);
    chk("fetch_done_pcen", 32'(ifh.pcen), 1);
    chk("fetch_done_state", 32'(ifh.state), 0);
    step();
    chk("decode_state", 32'(ifh.state), 1);
    step(); step(); step();
    chk("addi_back_fetch", 32'(ifh.state), 0);

    imm_check(ADDI, 1'b0, 4'b0010);
    imm_check(ANDI, 1'b1, 4'b0000);

    br_check(BNE, 1'b1, 1'b0, 1'b0);
    br_check(BNE, 1'b0, 1'b0, 1'b1);
    br_check(BLE, 1'b0, 1'b1, 1'b1);
    br_check(BEQ, 1'b1, 1'b0, 1'b1);

    // jal
    op = JAL; memready = 1'b1;
    step(); step();
    chk("jal_state", 32'(ifh.state), 14);
    chk("jal_pcen", 32'(ifh.pcen), 1);
    chk("jal_regwrite", 32'(ifh.regwrite), 1);
    chk("jal_regdst", 32'(ifh.regdst), 2);
    chk("jal_memtoreg", 32'(ifh.memtoreg), 2);
    chk("jal_pcsrc", 32'(ifh.pcsrc), 2);
    step();
    chk("jal_back_fetch", 32'(ifh.state), 0);

    // Zero-wait cycles per instruction.
    run_instr(LW, 6'b0, 100, c);        chk("cpi_lw", 32'(c), 5);
    run_instr(SW, 6'b0, 100, c);        chk("cpi_sw", 32'(c), 4);
    run_instr(R, 6'b100010, 100, c);    chk("cpi_r", 32'(c), 4);
    run_instr(ORI, 6'b0, 100, c);       chk("cpi_imm", 32'(c), 4);
    run_instr(BEQ, 6'b0, 100, c);       chk("cpi_br", 32'(c), 3);
    run_instr(J, 6'b0, 100, c);         chk("cpi_j", 32'(c), 3);
    run_instr(R, FJR, 100, c);          chk("cpi_jr", 32'(c), 3);

    // Memory timeout in MEMRD.
    op = LW; memready = 1'b1;
    step(); step(); step();
    chk("memrd_state", 32'(ifh.state), 3);
    memready = 1'b0;
    repeat (15) step();
    chk("memrd_still_waiting", 32'(ifh.state), 3);
    chk("memrd_memread", 32'(ifh.memread), 1);
    step();
    chk("timeout_halt", 32'(ifh.state), 31);
    chk("timeout_buserr", 32'(ifh.buserr), 1);
    chk("timeout_memread", 32'(ifh.memread), 0);
    step();
    chk("halt_sticky", 32'(ifh.state), 31);
    reset = 1'b1;
    step();
    chk("reset_exit_halt", 32'(ifh.state), 0);
    chk("reset_clr_buserr", 32'(ifh.buserr), 0);
    reset = 1'b0;

    // Reset in the middle of a write wait.
    op = SW; memready = 1'b1;
    step(); step(); step();
    memready = 1'b0;
    step(); step(); #1;
    chk("memwr_wait_memwrite", 32'(ifh.memwrite), 1);
    reset = 1'b1; #1;
    chk("memwr_reset_memwrite", 32'(ifh.memwrite), 0);
    step();
    chk("memwr_reset_fetch", 32'(ifh.state), 0);
    reset = 1'b0;

    // Illegal opcode and unsupported funct on both variants.
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 6'b111111 : R; funct = 6'b000000; memready = 1'b1;
      step(); step();
      chk("illegal_halt_state", 32'(ifh.state), 31);
      chk("illegal_halt_flag", 32'(ifh.illegal), 1);
      chk("illegal_nop_state", 32'(ifn.state), 0);
      chk("illegal_nop_flag", 32'(ifn.illegal), 1);
      do_reset();
      chk("illegal_reset_clr", 32'(ifh.illegal), 0);
    end

    // Randomized instruction stream with random memory latency.
    for (int i = 0; i < 300; i++) begin
      o = ops[$urandom_range(11)];
      f = fns[$urandom_range(6)];
      if ($urandom_range(19) == 0) o = 6'b111111;
      if ($urandom_range(19) == 0) begin o = R; f = 6'b000001; end
      run_instr(o, f, int'($urandom_range(100, 40)), c);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Next-generation multi-cycle MIPS control unit: main FSM plus ALU decode, driving the existing multi-cycle datapath. Compared with the current controller it adds a variable-latency memory handshake (memready) with a timeout, the bne/slti/andi/ori/jal/jr instructions, and sticky error flags with a halt/skip mode. All outputs except the flags and the state register are combinational decodes of the state register, op, funct and the status inputs.

Parameters:
TIMEOUT, 15, wait cycles on one memory access before a bus error; 0 disables the timeout
WAIT_W, 4, width of the wait counter; TIMEOUT must be < 2**WAIT_W
HALT_ON_ILLEGAL, 1, 1 = illegal op/funct goes to HALT; 0 = sets the flag and returns to FETCH (NOP)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
lt  in  1  ALU result[31] (sign of a-b)
memready  in  1  memory completes the access this cycle
pcen  out  1  PC register enable
memread  out  1  read request
memwrite  out  1  write request
irwrite  out  1  instruction register enable
regwrite  out  1  register file write
alusrca  out  1  0=pc, 1=A
iord  out  1  0=pc, 1=aluout address
extop  out  1  0=sign-extend, 1=zero-extend the immediate
memtoreg  out  2  00=aluout, 01=data, 10=pc
regdst  out  2  00=rt, 01=rd, 10=r31
alusrcb  out  2  00=B, 01=4, 10=imm, 11=imm<<2
pcsrc  out  2  00=aluresult, 01=aluout, 10=jump target, 11=A
alucontrol  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1111 sltu
state  out  5  current state (debug)
buserr  out  1  sticky memory timeout flag
illegal  out  1  sticky illegal instruction flag

Behaviour:
- Reset (sync): state=FETCH(0), waitcnt=0, buserr=0, illegal=0. While reset=1, pcen, memread, memwrite, irwrite and regwrite are forced to 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, BLEEX 12, BNEEX 13, JALEX 14, JREX 15, HALT 31.
- Opcodes: lw 100011, sw 101011, R 000000, beq 000100, bne 000101, ble 000111, addi 001000, slti 001010, andi 001100, ori 001101, j 000010, jal 000011.
- Supported R-type funct values: 100000, 100010, 100100, 100101, 101010, 101011 (alucontrol per Ports); 001000 is jr.
- Memory states (FETCH, MEMRD, MEMWR):
  - memread or memwrite is held high every cycle in the state.
  - The state is left only in the cycle memready=1.
  - waitcnt increments on each cycle with memready=0 and clears when the state is left.
  - If TIMEOUT!=0 and waitcnt==TIMEOUT with memready=0: next state HALT, buserr<=1.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite=1 and pcen=1 only in the memready=1 cycle, so the PC advances exactly once.
- DECODE: alusrca=0, alusrcb=11, add, so aluout holds the branch target. Dispatch:
  - lw/sw -> MEMADR; R (funct != jr) -> RTYPEEX; R with jr -> JREX.
  - beq -> BEQEX; bne -> BNEEX; ble -> BLEEX.
  - addi/slti/andi/ori -> IMMEX; j -> JEX; jal -> JALEX.
  - Unknown op, or R-type with unsupported funct: illegal<=1, next = HALT if HALT_ON_ILLEGAL else FETCH.
- MEMADR: alusrca=1, alusrcb=10, add; next MEMRD (lw) or MEMWR (sw). MEMRD: iord=1, then -> MEMWB. MEMWB: regwrite, regdst=00, memtoreg=01. MEMWR: iord=1, memwrite.
- RTYPEEX: alusrca=1, alusrcb=00, funct-decoded alucontrol. RTYPEWB: regwrite, regdst=01, memtoreg=00.
- BEQEX/BNEEX/BLEEX: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero (beq), ~zero (bne), zero|lt (ble).
- IMMEX: alusrca=1, alusrcb=10. alucontrol: addi add, slti slt, andi and, ori or. extop=1 for andi/ori only. IMMWB: regwrite, regdst=00, memtoreg=00; extop and alucontrol are held.
- JEX: pcen, pcsrc=10.
- JALEX: pcen, pcsrc=10, regwrite, regdst=10, memtoreg=10. The write data is the already-incremented PC (pc+4), captured at the same edge the PC loads the target.
- JREX: pcen, pcsrc=11.
- HALT: all enables and requests 0; only reset exits.
- Every terminal state returns to FETCH. Don't-care outputs drive 0.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R 4, imm 4, branch 3, j/jal/jr 3. Each memory wait cycle adds 1.
- Reset mid-wait abandons the access immediately: next cycle is FETCH, memwrite is low, and the flags clear.

Test Plan:
1. Fetch with memready low for 3 cycles, then high: irwrite and pcen pulse exactly once, in the 4th FETCH cycle; state 0 -> 1.
2. addi, then andi: IMMEX drives extop 0 then 1, alucontrol 0010 then 0000. Each takes 4 cycles (zero-wait); IMMWB has regwrite=1, regdst=00.
3. bne with zero=1: pcen=0. bne with zero=0: pcen=1, pcsrc=01. ble with lt=1, zero=0: pcen=1.
4. jal: JALEX has pcen=1, regwrite=1, regdst=10, memtoreg=10, pcsrc=10; returns to FETCH after 3 cycles total.
5. TIMEOUT=15, lw with memready held 0 in MEMRD: after 15 wait cycles -> HALT(31), buserr=1, memread=0 thereafter. Reset -> FETCH with buserr=0.
6. op=111111 with HALT_ON_ILLEGAL=1 -> HALT and illegal=1; with HALT_ON_ILLEGAL=0 -> FETCH, illegal=1, no regwrite/memwrite issued. R-type funct 000000 behaves the same.
